rr_arbiter_8way: RTL and testbench
==================================

Name: rr_arbiter_8way

Overview:
- Round-robin arbiter that shares one resource between 8 requesters and issues a registered one-hot grant.
- The combinational or_8way_gate reduces the request vector to "any request", which wakes the arbiter from IDLE.
- The granted requester holds ownership until it signals done or withdraws its request.
- First sequencing block above the Week1 gate library; later bus, memory and peripheral sharing builds on it.

Parameters:
- N_REQ, 8, number of requesters; fixed at 8 to match the or_8way_gate width; other values unsupported.
- MAX_HOLD, 16, maximum grant duration in cycles when ARB_TIMEOUT_EN is defined; range 1..255.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- req  input  8  request lines, bit i = requester i; level-sensitive.
- done  input  1  current owner releases the resource; sampled only in GRANT.
- grant  output  8  registered one-hot grant; all-zero when idle.
- grant_idx  output  3  binary index of the current grant; valid when busy=1.
- busy  output  1  high while any grant is held.
- any_req  output  1  combinational OR of req (or_8way_gate output).
- timeout  output  1  one-cycle pulse on forced release; tied 0 without ARB_TIMEOUT_EN.

Behaviour:
- One clock; reset is synchronous and active-high, using ports clk and reset.
- Reset values: grant=0, grant_idx=0, busy=0, timeout=0, state=IDLE, prio pointer=0, hold counter=0.
- Reset mid-grant: all of the above take effect at the next edge. No release pulse is generated.
- States are IDLE and GRANT.
- IDLE, any_req=0: stay in IDLE; outputs remain 0.
- IDLE, any_req=1:
  - Winner is the first set bit scanning prio, prio+1, ... with wrap modulo 8 (7 wraps to 0).
  - Next edge: grant=onehot(winner), grant_idx=winner, busy=1, state=GRANT.
  - Latency is exactly 1 cycle from req sampled high to grant high.
- GRANT, hold condition: stay while req[grant_idx]=1 and done=0. grant is stable, with no glitch or re-arbitration.
- GRANT, release condition: done=1, or req[grant_idx]=0.
  - Next edge: grant=0, busy=0, state=IDLE, prio=(grant_idx+1) mod 8.
  - done and a request drop in the same cycle form a single release.
- Minimum one idle cycle between consecutive grants, so back-to-back ownership changes take 2 cycles.
- Requests from non-granted bits during GRANT are ignored until the return to IDLE. No request is latched; req must still be high when sampled in IDLE.
- A single requester holding req high receives repeated grants: it releases via done, returns to IDLE for one cycle, then is re-granted. Fairness comes from prio.
- done in IDLE is ignored.
- grant is always zero or exactly one bit (one-hot invariant).
- Outputs never change except on a clock edge, apart from the combinational any_req.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit hold counter clears on entry to GRANT and increments each GRANT cycle.
  - When the counter equals MAX_HOLD-1 with no normal release, the next edge performs a forced release: grant=0, busy=0, prio advances, and timeout=1 for exactly that one cycle.
  - A normal release in the same cycle takes precedence, with timeout=0.
- Undefined: no counter; grants are held indefinitely; timeout is tied to 0.

Decomposition:
- Shared package/header arb_defs:
  - State encoding: IDLE=1'b0, GRANT=1'b1.
  - N_REQ=8 and IDX_W=3.
  - Default MAX_HOLD.
- Sub-module: instantiate the existing or_8way_gate to produce any_req. The priority scan stays inline as a rotate-then-priority-encode function.

Test Plan:
- reset=1 for 2 cycles with req=8'hFF -> grant=0, busy=0, grant_idx=0. After release, the first edge gives grant=8'b00000001.
- req=8'b00010000 from IDLE -> next cycle grant=8'b00010000, grant_idx=4. Then done=1 for one cycle -> grant=0 next edge, and a later grant starts the scan from index 5.
- req=8'hFF, pulse done every grant -> grant sequence idx 0,1,2,...,7,0, with one idle cycle between each.
- Granted req[2] drops while req[6]=1 -> release next edge, then grant=8'b01000000 one cycle later. Also: reset asserted while grant=8'b01000000 -> grant=0 next edge, prio=0.
- req=8'b00100110 with prio=3 -> grant=8'b00100000 (idx 5). Also: simultaneous done=1 and req drop -> a single release, busy low for one cycle only.
- ARB_TIMEOUT_EN defined, MAX_HOLD=4, req[1] held with done=0 -> grant is high for exactly 4 cycles, then grant=0 with a timeout pulse of 1 cycle. Undefined -> grant is still held after 100 cycles and timeout stays 0.

Source files
------------

// File: rtl/arb_defs_pkg.sv
// rtl/arb_defs_pkg.sv - shared constants, state encoding and priority scan for rr_arbiter_8way
package arb_defs;

  localparam int N_REQ        = 8;
  localparam int IDX_W        = 3;
  localparam int MAX_HOLD_DEF = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Rotate so prio lands at bit 0, take the lowest set bit, then rotate the index back.
  function automatic logic [IDX_W-1:0] pick_winner(input logic [N_REQ-1:0] r,
                                                   input logic [IDX_W-1:0] p);
    logic [2*N_REQ-2:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [IDX_W-1:0]   off;
    dbl = {r[N_REQ-2:0], r};
    rot = dbl[p +: N_REQ];
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = IDX_W'(i);
    end
    return p + off;
  endfunction

endpackage

// File: rtl/or_8way_gate.sv
// rtl/or_8way_gate.sv - combinational 8-input OR reduction
module or_8way_gate (
  input  logic [7:0] a_i,
  output logic       y_o
);

  assign y_o = |a_i;

endmodule

// File: rtl/rr_arbiter_8way.sv
// rtl/rr_arbiter_8way.sv - 8-way round-robin arbiter with registered one-hot grant
// Optional grant timeout enabled by ARB_TIMEOUT_EN.
module rr_arbiter_8way
  import arb_defs::*;
`ifdef ARB_TIMEOUT_EN
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF
)
`endif
(
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             busy,
  output logic             any_req,
  output logic             timeout
);

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] prio_q, prio_d;
  logic             busy_q, busy_d;
  logic             timeout_q, timeout_d;
  logic [IDX_W-1:0] winner;
  logic             normal_rel;
  logic             forced_rel;

  or_8way_gate u_or (
    .a_i (req),
    .y_o (any_req)
  );

  assign winner     = pick_winner(req, prio_q);
  assign normal_rel = (state_q == GRANT) && (done || !req[idx_q]);

`ifdef ARB_TIMEOUT_EN
  logic [7:0] hold_q, hold_d;

  // A normal release wins over a timeout in the same cycle.
  assign forced_rel = (state_q == GRANT) && !normal_rel && (hold_q == 8'(MAX_HOLD - 1));

  always_comb begin
    hold_d = hold_q;
    if (state_q == IDLE) hold_d = '0;
    else                 hold_d = hold_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) hold_q <= '0;
    else       hold_q <= hold_d;
  end
`else
  assign forced_rel = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = GRANT;
      GRANT:   if (normal_rel || forced_rel) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant_d   = grant_q;
    idx_d     = idx_q;
    prio_d    = prio_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        grant_d = '0;
        busy_d  = 1'b0;
        if (any_req) begin
          grant_d = N_REQ'(1) << winner;
          idx_d   = winner;
          busy_d  = 1'b1;
        end
      end
      GRANT: begin
        if (normal_rel || forced_rel) begin
          grant_d   = '0;
          busy_d    = 1'b0;
          prio_d    = idx_q + IDX_W'(1);
          timeout_d = forced_rel;
        end
      end
      default: begin
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grant_q   <= '0;
      idx_q     <= '0;
      prio_q    <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      grant_q   <= grant_d;
      idx_q     <= idx_d;
      prio_q    <= prio_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant     = grant_q;
  assign grant_idx = idx_q;
  assign busy      = busy_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_8way.sv
// tb/tb_rr_arbiter_8way.sv - self-checking bench for rr_arbiter_8way
module tb_rr_arbiter_8way;

`ifdef ARB_TIMEOUT_EN
  localparam int TB_MAX_HOLD = 4;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] req = 8'h00;
  logic       done = 1'b0;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       busy;
  logic       any_req;
  logic       timeout;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference state: owner index or -1 when nobody holds the resource.
  int m_owner = -1;
  int m_prio  = 0;
  int m_hold  = 0;
  bit m_tmo   = 1'b0;

  always #5 clk = ~clk;

`ifdef ARB_TIMEOUT_EN
  rr_arbiter_8way #(.MAX_HOLD(TB_MAX_HOLD)) dut (
`else
  rr_arbiter_8way dut (
`endif
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .done      (done),
    .grant     (grant),
    .grant_idx (grant_idx),
    .busy      (busy),
    .any_req   (any_req),
    .timeout   (timeout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_update();
    bit normal, forced;
    if (reset) begin
      m_owner = -1; m_prio = 0; m_hold = 0; m_tmo = 1'b0;
    end else if (m_owner < 0) begin
      m_tmo = 1'b0;
      for (int k = 0; k < 8; k++) begin
        if (m_owner < 0 && req[(m_prio + k) % 8]) m_owner = (m_prio + k) % 8;
      end
      m_hold = 0;
    end else begin
      normal = done || !req[m_owner];
`ifdef ARB_TIMEOUT_EN
      forced = !normal && (m_hold == TB_MAX_HOLD - 1);
`else
      forced = 1'b0;
`endif
      if (normal || forced) begin
        m_prio  = (m_owner + 1) % 8;
        m_owner = -1;
        m_tmo   = forced;
      end else begin
        m_hold++;
        m_tmo = 1'b0;
      end
    end
  endtask

  task automatic step(input logic [7:0] r, input logic d, input logic rs);
    logic [7:0] exp_g;
    @(negedge clk);
    req = r; done = d; reset = rs;
    #1;
    check("any_req", 32'(any_req), 32'(|r));
    @(posedge clk);
    model_update();
    #1;
    exp_g = (m_owner < 0) ? 8'h00 : (8'h01 << m_owner);
    check("grant", 32'(grant), 32'(exp_g));
    check("busy", 32'(busy), 32'(m_owner >= 0));
    check("timeout", 32'(timeout), 32'(m_tmo));
    check("onehot", 32'($countones(grant) <= 1), 32'd1);
    if (m_owner >= 0) check("grant_idx", 32'(grant_idx), 32'(m_owner));
  endtask

  initial begin
    int cnt;

    step(8'hFF, 1'b0, 1'b1);
    step(8'hFF, 1'b0, 1'b1);
    check("rst_grant", 32'(grant), 32'h00);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_idx", 32'(grant_idx), 32'd0);
    check("rst_tmo", 32'(timeout), 32'd0);
    step(8'hFF, 1'b0, 1'b0);
    check("first_grant", 32'(grant), 32'h01);
    step(8'h00, 1'b0, 1'b0);

    // Single requester, done release, then scan resumes from index 5.
    step(8'h10, 1'b0, 1'b0);
    check("g4", 32'(grant), 32'h10);
    check("g4_idx", 32'(grant_idx), 32'd4);
    step(8'h10, 1'b1, 1'b0);
    check("g4_rel", 32'(grant), 32'h00);
    step(8'h21, 1'b0, 1'b0);
    check("scan_from5", 32'(grant), 32'h20);
    step(8'h00, 1'b0, 1'b0);

    // Full rotation with done pulsed on every grant.
    step(8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) begin
      step(8'hFF, 1'b0, 1'b0);
      check("rr_seq", 32'(grant_idx), 32'(i % 8));
      check("rr_busy", 32'(busy), 32'd1);
      step(8'hFF, 1'b1, 1'b0);
      check("rr_gap", 32'(busy), 32'd0);
    end

    // Owner withdraws, waiting requester follows; then reset mid-grant.
    step(8'h00, 1'b0, 1'b1);
    step(8'h44, 1'b0, 1'b0);
    check("g2", 32'(grant), 32'h04);
    step(8'h40, 1'b0, 1'b0);
    check("drop_rel", 32'(grant), 32'h00);
    step(8'h40, 1'b0, 1'b0);
    check("g6", 32'(grant), 32'h40);
    step(8'h40, 1'b0, 1'b1);
    check("rst_mid", 32'(grant), 32'h00);
    check("rst_mid_tmo", 32'(timeout), 32'd0);
    step(8'hFF, 1'b0, 1'b0);
    check("prio_reset", 32'(grant), 32'h01);
    step(8'h00, 1'b0, 1'b0);

    // prio=3 scan, then simultaneous done and drop.
    step(8'h00, 1'b0, 1'b1);
    step(8'h04, 1'b0, 1'b0);
    step(8'h04, 1'b1, 1'b0);
    step(8'h26, 1'b0, 1'b0);
    check("p3_win", 32'(grant), 32'h20);
    check("p3_idx", 32'(grant_idx), 32'd5);
    step(8'h06, 1'b1, 1'b0);
    check("dbl_rel", 32'(busy), 32'd0);
    step(8'h06, 1'b0, 1'b0);
    check("dbl_one_idle", 32'(busy), 32'd1);
    check("dbl_next", 32'(grant), 32'h02);
    step(8'h00, 1'b0, 1'b0);

    // Long hold by requester 1.
    step(8'h00, 1'b0, 1'b1);
    step(8'h02, 1'b0, 1'b0);
`ifdef ARB_TIMEOUT_EN
    cnt = 1;
    for (int k = 0; k < 20 && grant != 8'h00; k++) begin
      step(8'h02, 1'b0, 1'b0);
      if (grant != 8'h00) cnt++;
    end
    check("hold_len", 32'(cnt), 32'(TB_MAX_HOLD));
    check("tmo_pulse", 32'(timeout), 32'd1);
    step(8'h02, 1'b0, 1'b0);
    check("tmo_clear", 32'(timeout), 32'd0);
    check("tmo_regrant", 32'(grant), 32'h02);
`else
    cnt = 0;
    repeat (100) begin
      step(8'h02, 1'b0, 1'b0);
      cnt += timeout;
    end
    check("hold_forever", 32'(grant), 32'h02);
    check("no_tmo", 32'(cnt), 32'd0);
`endif

    // Random traffic: requests mostly stable so grants persist.
    for (int i = 0; i < 2000; i++) begin
      logic [7:0] r;
      r = req;
      if ($urandom_range(3) == 0) r = 8'($urandom);
      step(r, ($urandom_range(4) == 0), ($urandom_range(63) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
